lsu_dmem_ctrl: RTL and testbench

- Load/store unit between the X stage (ALU address result, rs2 store data, decoded memory control) and the core's dmem valid/ready request/response port.
- Feeds the M stage with extended load data.
- Registers one memory operation at a time, drives the dmem request until accepted, optionally waits for a response, and aligns and extends the load data.
- Stalls the pipeline while an operation is in flight.

---
 rtl/lsu_dmem_ctrl_if.sv | 37 +++
 rtl/lsu_dmem_ctrl.sv | 121 ++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_ctrl_if.sv
// rtl/lsu_dmem_ctrl_if.sv - dmem request/response channel between the LSU and the memory port
// Request and response both carry a mem_pkt_t {mtype, addr, len, data}; mtype 1 = WRITE, 0 = READ.
interface lsu_dmem_ctrl_if #(
   parameter int N_BITS = 32
);
   typedef struct packed {
      logic              mtype;
      logic [N_BITS-1:0] addr;
      logic [1:0]        len;
      logic [N_BITS-1:0] data;
   } mem_pkt_t;

   logic     req_vld;
   logic     req_rdy;
   mem_pkt_t req;
   logic     rsp_vld;
   logic     rsp_rdy;
   mem_pkt_t rsp;

   modport master (
      output req_vld,
      input  req_rdy,
      output req,
      input  rsp_vld,
      output rsp_rdy,
      input  rsp
   );

   modport slave (
      input  req_vld,
      output req_rdy,
      input  req,
      output rsp_vld,
      input  rsp_rdy,
      output rsp
   );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// rtl/lsu_dmem_ctrl.sv - load/store unit: one dmem op in flight, load data alignment/extension
// IDLE -> REQ -> RSP -> DONE; misaligned accesses skip straight to DONE without touching dmem.
module lsu_dmem_ctrl #(
   parameter int N_BITS         = 32,
   parameter bit STORE_WAIT_RSP = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              x_mem_vld,
   input  logic              x_mem_we,
   input  logic [2:0]        x_mem_funct3,
   input  logic [N_BITS-1:0] x_addr,
   input  logic [N_BITS-1:0] x_st_data,
   output logic              stall,
   output logic              m_done,
   output logic [N_BITS-1:0] m_ld_data,
   output logic              m_misaligned,
   lsu_dmem_ctrl_if.master   dmem
);

   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

   state_t     state;
   logic       we_q;
   logic [2:0] f3_q;
   logic       x_misaligned;
   logic       unused_rsp;

   // funct3[1] set means word class, which also absorbs the reserved encodings 011/110/111
   function automatic logic [1:0] size_len(input logic [2:0] f3);
      if (f3[1])      return 2'd0;
      else if (f3[0]) return 2'd2;
      else            return 2'd1;
   endfunction

   function automatic logic [N_BITS-1:0] size_mask(input logic [2:0] f3, input logic [N_BITS-1:0] d);
      if (f3[1])      return d;
      else if (f3[0]) return {{(N_BITS-16){1'b0}}, d[15:0]};
      else            return {{(N_BITS-8){1'b0}}, d[7:0]};
   endfunction

   function automatic logic [N_BITS-1:0] extend(input logic [2:0] f3, input logic [N_BITS-1:0] d);
      if (f3[1])      return d;
      else if (f3[0]) return {{(N_BITS-16){~f3[2] & d[15]}}, d[15:0]};
      else            return {{(N_BITS-8){~f3[2] & d[7]}}, d[7:0]};
   endfunction

   always_comb begin
      x_misaligned = 1'b0;
      if (x_mem_funct3[1])      x_misaligned = |x_addr[1:0];
      else if (x_mem_funct3[0]) x_misaligned = x_addr[0];
   end

   assign stall      = (state == REQ) | (state == RSP) | ((state == IDLE) & x_mem_vld);
   assign unused_rsp = ^{dmem.rsp.mtype, dmem.rsp.addr, dmem.rsp.len};

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'd0;
         m_done       <= 1'b0;
         m_ld_data    <= '0;
         m_misaligned <= 1'b0;
         dmem.req_vld <= 1'b0;
         dmem.req     <= '0;
         dmem.rsp_rdy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (x_mem_vld) begin
                  if (x_misaligned) begin
                     m_done       <= 1'b1;
                     m_misaligned <= 1'b1;
                     m_ld_data    <= '0;
                     state        <= DONE;
                  end else begin
                     we_q            <= x_mem_we;
                     f3_q            <= x_mem_funct3;
                     dmem.req_vld    <= 1'b1;
                     dmem.req.mtype  <= x_mem_we;
                     dmem.req.addr   <= x_addr;
                     dmem.req.len    <= size_len(x_mem_funct3);
                     dmem.req.data   <= x_mem_we ? size_mask(x_mem_funct3, x_st_data) : '0;
                     state           <= REQ;
                  end
               end
            end
            REQ: begin
               if (dmem.req_rdy) begin
                  dmem.req_vld <= 1'b0;
                  if (we_q && !STORE_WAIT_RSP) begin
                     m_done    <= 1'b1;
                     m_ld_data <= '0;
                     state     <= DONE;
                  end else begin
                     dmem.rsp_rdy <= 1'b1;
                     state        <= RSP;
                  end
               end
            end
            RSP: begin
               if (dmem.rsp_vld) begin
                  dmem.rsp_rdy <= 1'b0;
                  m_done       <= 1'b1;
                  m_ld_data    <= we_q ? '0 : extend(f3_q, dmem.rsp.data);
                  state        <= DONE;
               end
            end
            DONE: begin
               // x_mem_vld seen here still belongs to the op just finished
               m_done       <= 1'b0;
               m_misaligned <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb/tb_lsu_dmem_ctrl.sv - table-driven bench for lsu_dmem_ctrl (both store completion modes)
module tb_lsu_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        x_vld1 = 1'b0, x_vld0 = 1'b0;
   logic        x_we = 1'b0;
   logic [2:0]  x_f3 = 3'd0;
   logic [31:0] x_addr = '0, x_st = '0;
   logic        rdy = 1'b0, rsp_vld = 1'b0;
   logic [31:0] rsp_data = '0;

   logic        stall1, done1, mis1, stall0, done0, mis0;
   logic [31:0] ld1, ld0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_dmem_ctrl_if #(.N_BITS(32)) dm1 ();
   lsu_dmem_ctrl_if #(.N_BITS(32)) dm0 ();

   assign dm1.req_rdy = rdy;
   assign dm1.rsp_vld = rsp_vld;
   assign dm1.rsp     = {1'b0, 32'h0, 2'b00, rsp_data};
   assign dm0.req_rdy = rdy;
   assign dm0.rsp_vld = rsp_vld;
   assign dm0.rsp     = {1'b0, 32'h0, 2'b00, rsp_data};

   lsu_dmem_ctrl #(.N_BITS(32), .STORE_WAIT_RSP(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .x_mem_vld(x_vld1), .x_mem_we(x_we), .x_mem_funct3(x_f3),
      .x_addr(x_addr), .x_st_data(x_st), .stall(stall1), .m_done(done1),
      .m_ld_data(ld1), .m_misaligned(mis1), .dmem(dm1.master)
   );

   lsu_dmem_ctrl #(.N_BITS(32), .STORE_WAIT_RSP(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .x_mem_vld(x_vld0), .x_mem_we(x_we), .x_mem_funct3(x_f3),
      .x_addr(x_addr), .x_st_data(x_st), .stall(stall0), .m_done(done0),
      .m_ld_data(ld0), .m_misaligned(mis0), .dmem(dm0.master)
   );

   typedef struct {
      logic        d0;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] st;
      logic [31:0] rsp;
      int          rdy_dly;
      int          rsp_dly;
      logic        mis;
      logic [1:0]  len;
      logic [31:0] req_data;
      logic [31:0] ld;
      int          lat;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  reqc = 0, rspc = 0, acc = 0, stallc = 0, cyc_done = -1;
      logic s_req_vld, s_rsp_rdy, s_done, s_stall, s_mis;
      logic [31:0] s_ld;
      x_vld1 = ~v.d0; x_vld0 = v.d0;
      x_we = v.we; x_f3 = v.f3; x_addr = v.addr; x_st = v.st;
      rsp_data = v.rsp; rdy = 1'b0; rsp_vld = 1'b0;
      #1;
      if (v.d0 ? stall0 : stall1) stallc++;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         s_req_vld = v.d0 ? dm0.req_vld : dm1.req_vld;
         s_rsp_rdy = v.d0 ? dm0.rsp_rdy : dm1.rsp_rdy;
         s_done    = v.d0 ? done0 : done1;
         s_stall   = v.d0 ? stall0 : stall1;
         s_mis     = v.d0 ? mis0 : mis1;
         s_ld      = v.d0 ? ld0 : ld1;
         if (s_stall) stallc++;
         if (s_req_vld) begin
            reqc++;
            chk($sformatf("v%0d_req_mtype", idx), {31'd0, v.d0 ? dm0.req.mtype : dm1.req.mtype}, {31'd0, v.we});
            chk($sformatf("v%0d_req_addr", idx), v.d0 ? dm0.req.addr : dm1.req.addr, v.addr);
            chk($sformatf("v%0d_req_len", idx), {30'd0, v.d0 ? dm0.req.len : dm1.req.len}, {30'd0, v.len});
            chk($sformatf("v%0d_req_data", idx), v.d0 ? dm0.req.data : dm1.req.data, v.req_data);
            rdy = (reqc > v.rdy_dly);
            if (rdy) acc++;
         end else begin
            rdy = 1'b0;
         end
         if (s_rsp_rdy) begin
            rspc++;
            rsp_vld = (rspc > v.rsp_dly);
         end else begin
            rsp_vld = 1'b0;
         end
         if (s_done) begin
            cyc_done = cyc;
            chk($sformatf("v%0d_ld_data", idx), s_ld, v.ld);
            chk($sformatf("v%0d_misaligned", idx), {31'd0, s_mis}, {31'd0, v.mis});
            break;
         end
      end
      rdy = 1'b0;
      rsp_vld = 1'b0;
      chk($sformatf("v%0d_latency", idx), cyc_done, v.lat);
      chk($sformatf("v%0d_accepts", idx), acc, v.mis ? 0 : 1);
      chk($sformatf("v%0d_stall_cycles", idx), stallc, v.lat);
      @(negedge clk);
      x_vld1 = 1'b0; x_vld0 = 1'b0;
      chk($sformatf("v%0d_no_reaccept", idx), {31'd0, v.d0 ? dm0.req_vld : dm1.req_vld}, 32'd0);
      chk($sformatf("v%0d_done_pulse", idx), {31'd0, v.d0 ? done0 : done1}, 32'd0);
      chk($sformatf("v%0d_ld_hold", idx), v.d0 ? ld0 : ld1, v.ld);
   endtask

   initial begin
      //          d0 we f3      addr          st            rsp           rdy rsp mis len   req_data      ld            lat
      vecs[0]  = '{0, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 2'd0, 32'h0,        32'hDEADBEEF, 3};
      vecs[1]  = '{0, 0, 3'b000, 32'h103, 32'h0,        32'h00000080, 0, 0, 0, 2'd1, 32'h0,        32'hFFFFFF80, 3};
      vecs[2]  = '{0, 0, 3'b100, 32'h103, 32'h0,        32'h00000080, 0, 0, 0, 2'd1, 32'h0,        32'h00000080, 3};
      vecs[3]  = '{0, 0, 3'b001, 32'h102, 32'h0,        32'h00008001, 0, 0, 0, 2'd2, 32'h0,        32'hFFFF8001, 3};
      vecs[4]  = '{0, 0, 3'b101, 32'h102, 32'h0,        32'h00008001, 0, 0, 0, 2'd2, 32'h0,        32'h00008001, 3};
      vecs[5]  = '{0, 1, 3'b000, 32'h200, 32'h12345678, 32'hFFFFFFFF, 4, 1, 0, 2'd1, 32'h78,       32'h0,        8};
      vecs[6]  = '{0, 0, 3'b010, 32'h104, 32'h0,        32'h11223344, 0, 0, 0, 2'd0, 32'h0,        32'h11223344, 3};
      vecs[7]  = '{0, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 0, 1, 2'd0, 32'h0,        32'h0,        1};
      vecs[8]  = '{0, 1, 3'b001, 32'h101, 32'hABCD,     32'h0,        0, 0, 1, 2'd2, 32'h0,        32'h0,        1};
      vecs[9]  = '{0, 0, 3'b110, 32'h104, 32'h0,        32'h80808080, 0, 0, 0, 2'd0, 32'h0,        32'h80808080, 3};
      vecs[10] = '{0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        0, 0, 0, 2'd0, 32'hCAFEF00D, 32'h0,        3};
      vecs[11] = '{0, 0, 3'b011, 32'h101, 32'h0,        32'h0,        0, 0, 1, 2'd0, 32'h0,        32'h0,        1};
      vecs[12] = '{0, 0, 3'b000, 32'h7,   32'h0,        32'h0000017F, 0, 2, 0, 2'd1, 32'h0,        32'h0000007F, 5};
      vecs[13] = '{1, 1, 3'b000, 32'h200, 32'h12345678, 32'h0,        4, 0, 0, 2'd1, 32'h78,       32'h0,        6};
      vecs[14] = '{1, 0, 3'b010, 32'h100, 32'h0,        32'h55AA55AA, 0, 0, 0, 2'd0, 32'h0,        32'h55AA55AA, 3};

      // reset state of both instances
      @(negedge clk);
      @(negedge clk);
      chk("rst_stall", {30'd0, stall1, stall0}, 32'd0);
      chk("rst_done", {30'd0, done1, done0}, 32'd0);
      chk("rst_mis", {30'd0, mis1, mis0}, 32'd0);
      chk("rst_ld", ld1 | ld0, 32'd0);
      chk("rst_req_vld", {30'd0, dm1.req_vld, dm0.req_vld}, 32'd0);
      chk("rst_rsp_rdy", {30'd0, dm1.rsp_rdy, dm0.rsp_rdy}, 32'd0);
      chk("rst_req_pkt", {31'd0, |{dm1.req, dm0.req}}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

      // reset while waiting in RSP aborts the op; a late response is ignored
      begin
         int guard = 0;
         x_vld1 = 1'b1; x_we = 1'b0; x_f3 = 3'b010; x_addr = 32'h100; rdy = 1'b1;
         rsp_data = 32'h13579BDF; rsp_vld = 1'b0;
         do begin
            @(negedge clk);
            guard++;
         end while (!dm1.rsp_rdy && guard < 10);
         chk("mid_rsp_reached", {31'd0, dm1.rsp_rdy}, 32'd1);
         rdy = 1'b0; x_vld1 = 1'b0; rst = 1'b1;
         @(negedge clk);
         chk("mid_rst_stall", {31'd0, stall1}, 32'd0);
         chk("mid_rst_req_vld", {31'd0, dm1.req_vld}, 32'd0);
         chk("mid_rst_rsp_rdy", {31'd0, dm1.rsp_rdy}, 32'd0);
         chk("mid_rst_done", {31'd0, done1}, 32'd0);
         chk("mid_rst_ld", ld1, 32'd0);
         chk("mid_rst_pkt", {31'd0, |dm1.req}, 32'd0);
         rst = 1'b0; rsp_vld = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("late_rsp_done_%0d", k), {31'd0, done1}, 32'd0);
            chk($sformatf("late_rsp_req_%0d", k), {31'd0, dm1.req_vld}, 32'd0);
         end
         rsp_vld = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
